// File: rtl/pwm_ctrl_pkg.sv
// Purpose : shared types and helpers for the PWM fade sequencer.
// Latency : n/a (types, constants and pure functions only).
// Backpr. : n/a.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } fade_state_t;

    // Full-scale duty (100%) for an R-bit PWM generator.
    function automatic int unsigned DUTY_FULL(input int unsigned r);
        return 32'd1 << r;
    endfunction

    // One step of duty toward target, never overshooting. Comparisons happen
    // before the subtraction, so nothing can wrap below 0 or above full scale.
    function automatic logic [31:0] clamp_step(input logic [31:0] duty,
                                               input logic [31:0] target,
                                               input logic [31:0] step);
        if (duty < target) begin
            return ((target - duty) < step) ? target : duty + step;
        end else if (duty > target) begin
            return ((duty - target) < step) ? target : duty - step;
        end
        return duty;
    endfunction

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Purpose : fade-command valid/ready bus into pwm_fade_ctrl.
// Latency : n/a (wires only); a command transfers on cfg_valid && cfg_ready.
// Backpr. : cfg_ready is low while a fade is in progress.
// Optional: cfg_loop exists only when PWM_FADE_BREATHE_EN is defined.
interface pwm_fade_ctrl_if #(
    parameter int R = 8
);
    logic         cfg_valid;
    logic         cfg_ready;
    logic [R:0]   cfg_target;
    logic [R:0]   cfg_step;
    logic [31:0]  cfg_tick;
    logic [31:0]  cfg_dvsr;
`ifdef PWM_FADE_BREATHE_EN
    logic         cfg_loop;
`endif

    modport master (
        output cfg_valid, cfg_target, cfg_step, cfg_tick, cfg_dvsr,
`ifdef PWM_FADE_BREATHE_EN
        output cfg_loop,
`endif
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_target, cfg_step, cfg_tick, cfg_dvsr,
`ifdef PWM_FADE_BREATHE_EN
        input  cfg_loop,
`endif
        output cfg_ready
    );
endinterface

// File: rtl/pwm_step_timer.sv
// Purpose : 32-bit loadable down-counter producing a periodic expire pulse.
// Latency : first expire load_val cycles after load, then every load_val cycles.
// Backpr. : none; counts only while en_i is high.
// Ports   : clk, rst (async active-low), load_i/load_val_i (0 treated as 1),
//           en_i (count enable), expire_o (1-cycle pulse, auto-reloads).
module pwm_step_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        en_i,
    output logic        expire_o
);
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] reload_q, reload_d;
    logic [31:0] load_norm;

    assign load_norm = (load_val_i == 32'd0) ? 32'd1 : load_val_i;
    assign expire_o  = en_i && (cnt_q == 32'd1);

    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        if (load_i) begin
            cnt_d    = load_norm;
            reload_d = load_norm;
        end else if (en_i) begin
            cnt_d = (cnt_q == 32'd1) ? reload_q : cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= 32'd1;
            reload_q <= 32'd1;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
        end
    end
endmodule

// File: rtl/pwm_fade_ctrl.sv
// Purpose : ramps registered duty toward a commanded target and drives dvsr
//           into pwm_enhanced; optional breathing loop (PWM_FADE_BREATHE_EN).
// Latency : dvsr updates on the accept edge; first duty step cfg_tick cycles
//           later, then every cfg_tick cycles; done 1 cycle after reaching target.
// Backpr. : cfg_ready high only in IDLE; abort blocks accept and stops a ramp.
// Ports   : clk, rst (async active-low), cfg (fade command bus), abort,
//           duty/dvsr (to pwm_enhanced), busy (ramping), done (1-cycle pulse).
module pwm_fade_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int          R        = 8,
    parameter logic [31:0] DVSR_RST = 32'd4882
) (
    input  logic           clk,
    input  logic           rst,
    pwm_fade_ctrl_if.slave cfg,
    input  logic           abort,
    output logic [R:0]     duty,
    output logic [31:0]    dvsr,
    output logic           busy,
    output logic           done
);
    localparam int         DW   = R + 1;
    localparam logic [R:0] FULL = DW'(DUTY_FULL(R));

    fade_state_t state_q, state_d;
    logic [R:0]  duty_q, duty_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [R:0]  target_q, target_d;
    logic [R:0]  step_q, step_d;
`ifdef PWM_FADE_BREATHE_EN
    logic [R:0]  start_q, start_d;
    logic        loop_q, loop_d;
    logic        pulse_q, pulse_d;
`endif

    logic        accept;
    logic        expire;
    logic [R:0]  norm_target;
    logic [R:0]  norm_step;
    logic [R:0]  duty_next;

    assign accept      = (state_q == IDLE) && cfg.cfg_valid && !abort;
    assign norm_target = (cfg.cfg_target > FULL) ? FULL : cfg.cfg_target;
    assign norm_step   = (cfg.cfg_step == '0) ? DW'(1) : cfg.cfg_step;
    assign duty_next   = DW'(clamp_step(32'(duty_q), 32'(target_q), 32'(step_q)));

    pwm_step_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (cfg.cfg_tick),
        .en_i       (state_q == RAMP),
        .expire_o   (expire)
    );

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        dvsr_d   = dvsr_q;
        target_d = target_q;
        step_d   = step_q;
`ifdef PWM_FADE_BREATHE_EN
        start_d  = start_q;
        loop_d   = loop_q;
        pulse_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    target_d = norm_target;
                    step_d   = norm_step;
                    dvsr_d   = cfg.cfg_dvsr;
`ifdef PWM_FADE_BREATHE_EN
                    start_d  = duty_q;
                    loop_d   = cfg.cfg_loop;
`endif
                    state_d  = (norm_target == duty_q) ? DONE : RAMP;
                end
            end
            RAMP: begin
                // abort wins over a step landing on the same edge
                if (abort) begin
                    state_d = IDLE;
                end else if (expire) begin
                    duty_d = duty_next;
                    if (duty_next == target_q) begin
`ifdef PWM_FADE_BREATHE_EN
                        if (loop_q) begin
                            // bounce between the two endpoints, staying busy
                            target_d = start_q;
                            start_d  = target_q;
                            pulse_d  = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            dvsr_q   <= DVSR_RST;
            target_q <= '0;
            step_q   <= DW'(1);
`ifdef PWM_FADE_BREATHE_EN
            start_q  <= '0;
            loop_q   <= 1'b0;
            pulse_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            dvsr_q   <= dvsr_d;
            target_q <= target_d;
            step_q   <= step_d;
`ifdef PWM_FADE_BREATHE_EN
            start_q  <= start_d;
            loop_q   <= loop_d;
            pulse_q  <= pulse_d;
`endif
        end
    end

    assign cfg.cfg_ready = (state_q == IDLE);
    assign busy          = (state_q == RAMP);
    assign duty          = duty_q;
    assign dvsr          = dvsr_q;
`ifdef PWM_FADE_BREATHE_EN
    assign done          = (state_q == DONE) || pulse_q;
`else
    assign done          = (state_q == DONE);
`endif
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
module tb_pwm_fade_ctrl;
    localparam int R    = 8;
    localparam int FULL = 256;

    logic        clk;
    logic        rst;
    logic        abort;
    logic [R:0]  duty;
    logic [31:0] dvsr;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int m_duty   = 0;
    int m_dvsr   = 4882;

    pwm_fade_ctrl_if #(.R(R)) cfg_if ();

    pwm_fade_ctrl #(.R(R), .DVSR_RST(32'd4882)) dut (
        .clk   (clk),
        .rst   (rst),
        .cfg   (cfg_if),
        .abort (abort),
        .duty  (duty),
        .dvsr  (dvsr),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Duty after k steps from s toward t; in loop mode endpoints swap on arrival.
    function automatic int ref_duty(input int s, input int t, input int st,
                                    input int k, input bit lp);
        int d, a, b, tmp;
        d = s; a = s; b = t;
        for (int i = 0; i < k; i++) begin
            if (d < b)      d = (b - d < st) ? b : d + st;
            else if (d > b) d = (d - b < st) ? b : d - st;
            if (lp && d == b) begin
                tmp = a; a = b; b = tmp;
            end
        end
        return d;
    endfunction

    task automatic idle_inputs();
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_target = '0;
        cfg_if.cfg_step   = '0;
        cfg_if.cfg_tick   = '0;
        cfg_if.cfg_dvsr   = '0;
`ifdef PWM_FADE_BREATHE_EN
        cfg_if.cfg_loop   = 1'b0;
`endif
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        n_checks++; if (duty !== 9'd0) begin n_fail++; $display("FAIL reset_duty got %0d exp 0", duty); end
        n_checks++; if (dvsr !== 32'd4882) begin n_fail++; $display("FAIL reset_dvsr got %0d exp 4882", dvsr); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", cfg_if.cfg_ready); end
        n_checks++; if (duty !== 9'd0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_release got duty=%0d busy=%b done=%b", duty, busy, done); end
        m_duty = 0;
        m_dvsr = 4882;
    endtask

    // Issues one command and checks duty/busy/done every cycle against the model.
    // abort_at>0 raises abort so that it is sampled on edge abort_at after accept.
    task automatic test_fade(input string name, input int tgt, input int stp,
                             input int tck, input int dv, input int abort_at,
                             input bit lp);
        int tn, sn, kn, diff, nsteps, total, lim, start, k, exp_d;
        logic exp_busy, exp_done;
        tn = (tgt > FULL) ? FULL : tgt;
        sn = (stp == 0) ? 1 : stp;
        kn = (tck == 0) ? 1 : tck;
        start  = m_duty;
        diff   = (tn > start) ? tn - start : start - tn;
        nsteps = (diff + sn - 1) / sn;
        total  = nsteps * kn;
        lim    = (lp && nsteps > 0) ? abort_at : total + 1;

        n_checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_before got %b exp 1", name, cfg_if.cfg_ready); end
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_target = 9'(tgt);
        cfg_if.cfg_step   = 9'(stp);
        cfg_if.cfg_tick   = 32'(tck);
        cfg_if.cfg_dvsr   = 32'(dv);
`ifdef PWM_FADE_BREATHE_EN
        cfg_if.cfg_loop   = lp;
`endif
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        n_checks++;
        if (dvsr !== 32'(dv)) begin n_fail++; $display("FAIL %s dvsr got %0d exp %0d", name, dvsr, dv); end

        for (int m = 0; m <= lim; m++) begin
            if (abort_at > 0 && m >= abort_at) begin
                exp_d = ref_duty(start, tn, sn, (abort_at - 1) / kn, lp);
                exp_busy = 1'b0; exp_done = 1'b0;
            end else if (lp && nsteps > 0) begin
                k = m / kn;
                exp_d = ref_duty(start, tn, sn, k, 1'b1);
                exp_busy = 1'b1;
                exp_done = (k > 0) && (m % kn == 0) && (exp_d == start || exp_d == tn);
            end else if (m < total) begin
                exp_d = ref_duty(start, tn, sn, m / kn, 1'b0);
                exp_busy = 1'b1; exp_done = 1'b0;
            end else if (m == total) begin
                exp_d = tn; exp_busy = 1'b0; exp_done = 1'b1;
            end else begin
                exp_d = tn; exp_busy = 1'b0; exp_done = 1'b0;
            end
            n_checks++;
            if (duty !== 9'(exp_d)) begin n_fail++; $display("FAIL %s duty m=%0d got %0d exp %0d", name, m, duty, exp_d); end
            n_checks++;
            if (busy !== exp_busy) begin n_fail++; $display("FAIL %s busy m=%0d got %b exp %b", name, m, busy, exp_busy); end
            n_checks++;
            if (done !== exp_done) begin n_fail++; $display("FAIL %s done m=%0d got %b exp %b", name, m, done, exp_done); end
            m_duty = exp_d;
            if (abort_at > 0 && m == abort_at) begin
                abort = 1'b0;
                break;
            end
            if (abort_at > 0 && m == abort_at - 1) abort = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_after got %b exp 1", name, cfg_if.cfg_ready); end
        m_dvsr = dv;
    endtask

    task automatic test_abort_idle();
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_target = 9'(m_duty + 40);
        cfg_if.cfg_step   = 9'd3;
        cfg_if.cfg_tick   = 32'd1;
        cfg_if.cfg_dvsr   = 32'd777;
        abort = 1'b1;
        @(negedge clk);
        idle_inputs();
        n_checks++; if (cfg_if.cfg_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle state got ready=%b busy=%b exp 1 0", cfg_if.cfg_ready, busy); end
        n_checks++; if (dvsr !== 32'(m_dvsr)) begin n_fail++; $display("FAIL abort_idle dvsr got %0d exp %0d", dvsr, m_dvsr); end
        @(negedge clk);
        n_checks++; if (duty !== 9'(m_duty) || done !== 1'b0) begin n_fail++; $display("FAIL abort_idle duty got %0d exp %0d done=%b", duty, m_duty, done); end
    endtask

    task automatic test_reset_mid_ramp();
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_target = 9'(m_duty > 100 ? 0 : 200);
        cfg_if.cfg_step   = 9'd7;
        cfg_if.cfg_tick   = 32'd2;
        cfg_if.cfg_dvsr   = 32'd31;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++; if (duty !== 9'd0 || dvsr !== 32'd4882) begin n_fail++; $display("FAIL mid_reset values got duty=%0d dvsr=%0d exp 0 4882", duty, dvsr); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_reset flags got busy=%b done=%b exp 0 0", busy, done); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset after got done=%b ready=%b exp 0 1", done, cfg_if.cfg_ready); end
        m_duty = 0;
        m_dvsr = 4882;
    endtask

    task automatic test_random();
        int tgt, stp, tck, dv, ab, tn, sn, kn, diff, total;
        for (int i = 0; i < 10; i++) begin
            tgt = $urandom_range(300, 0);
            stp = $urandom_range(60, 0);
            tck = $urandom_range(4, 0);
            dv  = int'($urandom_range(32'h7fff_ffff, 0));
            tn = (tgt > FULL) ? FULL : tgt;
            sn = (stp == 0) ? 1 : stp;
            kn = (tck == 0) ? 1 : tck;
            diff  = (tn > m_duty) ? tn - m_duty : m_duty - tn;
            total = ((diff + sn - 1) / sn) * kn;
            ab = 0;
            if (total > 0 && $urandom_range(3, 0) == 0) ab = $urandom_range(total, 1);
            test_fade("random", tgt, stp, tck, dv, ab, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_fade("ramp_up", 128, 16, 10, 100, 0, 1'b0);
        test_fade("clamp_down", 5, 50, 7, 100, 0, 1'b0);
        test_fade("saturate", 300, 64, 3, 123, 0, 1'b0);
        test_reset_mid_ramp();
        test_fade("abort_ramp", 200, 1, 4, 55, 41, 1'b0);
        test_abort_idle();
        test_fade("equal_target", m_duty, 5, 3, 66, 0, 1'b0);
        test_fade("step0_tick0", m_duty + 20, 0, 0, 88, 0, 1'b0);
        test_random();
`ifdef PWM_FADE_BREATHE_EN
        test_fade("to_zero", 0, 0, 0, 9, 0, 1'b0);
        test_fade("breathe", 64, 32, 2, 12, 21, 1'b1);
        test_fade("breathe_flat", m_duty, 4, 2, 13, 0, 1'b1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
- Sequencer that drives the duty and dvsr inputs of the pwm_enhanced generator.
- Accepts a fade command (target duty, step size, cycles per step, prescaler) over a valid/ready handshake.
- Ramps its registered duty output toward the target at a fixed rate, then signals completion.
- Sits between the register/control logic and pwm_enhanced; used for LED dimming and soft-start.

Parameters:
R, 8, PWM resolution; duty range is 0..2**R (2**R = 100%), duty width is R+1.
DVSR_RST, 4882, dvsr output value after reset.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cfg_valid  in  1  fade command valid
cfg_ready  out  1  command accepted when cfg_valid && cfg_ready at a rising clk edge
cfg_target  in  R+1  target duty
cfg_step  in  R+1  duty increment per step
cfg_tick  in  32  clk cycles per step
cfg_dvsr  in  32  prescaler forwarded to pwm_enhanced
abort  in  1  stop ramp immediately
duty  out  R+1  registered duty to pwm_enhanced
dvsr  out  32  registered prescaler to pwm_enhanced
busy  out  1  high in RAMP
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, duty=0, dvsr=DVSR_RST, busy=0, done=0, cfg_ready=1 once rst releases.
- States: IDLE, RAMP, DONE.
  - cfg_ready=1 only in IDLE.
  - busy=1 only in RAMP.
  - done=1 only in DONE.
- Accept (IDLE, cfg_valid, !abort):
  - Latch target and step; dvsr<=cfg_dvsr on the same edge.
  - Load the step timer with cfg_tick.
- Command normalisation:
  - cfg_target > 2**R saturates to 2**R.
  - cfg_step=0 is treated as 1.
  - cfg_tick=0 is treated as 1.
- Target equal to current duty at accept: go to DONE, no ramp; done is high on the cycle after accept.
- Otherwise go to RAMP.
- RAMP timing:
  - The timer counts down each cycle.
  - On expiry, duty moves toward target by step and the timer reloads.
  - The first duty change is visible cfg_tick cycles after the accept edge; subsequent changes every cfg_tick cycles.
- Clamping: a step never overshoots; if |target-duty| < step, duty <= target.
- Arithmetic: compute in R+2 bits, with no wrap at 0 or 2**R.
- Completion: on the edge where duty becomes target, go RAMP->DONE; done=1 for exactly one cycle, then IDLE.
- abort:
  - In RAMP: duty freezes at its current value, go to IDLE next edge, no done pulse.
  - In DONE: the done pulse still completes.
  - In IDLE: abort blocks accept on the same edge.
  - abort has priority over a simultaneous step.
- Between commands, duty and dvsr hold their last values.
- Reset mid-ramp: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: PWM_FADE_BREATHE_EN.
- Defined:
  - Adds input cfg_loop (1 bit), latched at accept.
  - With cfg_loop=1, reaching target latches the swap of the start duty (duty at accept) and target, and RAMP continues without passing through DONE.
  - A done pulse (1 cycle) is emitted at each endpoint while busy stays 1.
  - Only abort or reset ends the loop.
  - If start==target, behaves as non-loop.
- Undefined: cfg_loop port absent; every command ends in DONE->IDLE.

Decomposition:
- Package pwm_ctrl_pkg:
  - typedef enum fade_state_t {IDLE, RAMP, DONE}.
  - Localparam helper DUTY_FULL(R)=2**R.
  - Function clamp_step(duty, target, step) returning the next duty.
- Sub-module pwm_step_timer:
  - 32-bit loadable down-counter.
  - Inputs: load, load_val (0 mapped to 1), en.
  - Output: expire pulse (1 cycle) with auto-reload.

Test Plan:
- Reset then idle: rst low 3 cycles -> duty=0, dvsr=4882, cfg_ready=1, busy=0, done=0.
- Ramp up: target=128, step=16, tick=10, dvsr=100 -> dvsr=100 after accept; duty 16,32,...,128 every 10 cycles; busy for 80 cycles; single done pulse.
- Clamp and down ramp:
  - From duty=128, target=5, step=50 -> duty 78,28,5 with no underflow; done once.
  - Then target=300 -> saturates, ramps to 256.
- Abort: target=200, step=1, tick=4, abort at cycle 41 -> duty frozen at 10, IDLE next cycle, no done; abort+cfg_valid in IDLE -> not accepted.
- Degenerate commands:
  - target equals current duty -> done exactly 1 cycle after accept, duty unchanged.
  - step=0, tick=0 -> duty changes by 1 every cycle.
- PWM_FADE_BREATHE_EN: start 0, target 64, step 32, tick 2, loop=1 -> duty 32,64,32,0,32,... with done at each endpoint; abort stops the loop.
